wb_arbiter: RTL and testbench

//  Writeback arbiter feeding the register file's single write port (A3/WD/RFWr).

---
 rtl/wb_arbiter_pkg.sv | 16 +
 rtl/wb_fifo.sv | 78 +++++++
 rtl/wb_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared defaults and source-select encoding for the writeback arbiter.
// The arbiter chooses between the ALU bypass and the MEM/MDU result FIFO each cycle.
package wb_arbiter_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;

    // Owner of the single RF write slot in a given cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending MEM/MDU writebacks (destination + data).
// Exposes per-entry valid/rd taps so the top level can flag register hazards.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [AW-1:0]                 push_rd,
    input  logic [DW-1:0]                 push_wd,
    input  logic                          pop,
    output logic [AW-1:0]                 head_rd,
    output logic [DW-1:0]                 head_wd,
    output logic [$clog2(DEPTH):0]        occ,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0]              ent_vld,
    output logic [DEPTH-1:0][AW-1:0]      ent_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] occ_q;
    logic [AW-1:0] rd_mem [DEPTH];
    logic [DW-1:0] wd_mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = (occ_q == OW'(DEPTH));
    assign empty   = (occ_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign occ     = occ_q;
    assign head_rd = rd_mem[rd_ptr];
    assign head_wd = wd_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occ_q <= occ_q + OW'(push_ok) - OW'(pop_ok);
        end
    end

    // Payload storage needs no reset: validity comes from pointers and occupancy
    always_ff @(posedge clk) begin
        if (push_ok) begin
            rd_mem[wr_ptr] <= push_rd;
            wd_mem[wr_ptr] <= push_wd;
        end
    end

    always_comb begin
        logic [PW-1:0] offs;
        offs    = '0;
        ent_vld = '0;
        ent_rd  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs       = PW'(i) - rd_ptr;
            ent_vld[i] = ({1'b0, offs} < occ_q);
            ent_rd[i]  = rd_mem[i];
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results bypass straight to the RF port, MEM/MDU results
// queue in wb_fifo and drain into slots the ALU leaves idle.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_vld,
    input  logic [AW-1:0]          alu_rd,
    input  logic [DW-1:0]          alu_wd,
    input  logic                   mem_vld,
    output logic                   mem_rdy,
    input  logic [AW-1:0]          mem_rd,
    input  logic [DW-1:0]          mem_wd,
    input  logic                   mdu_vld,
    output logic                   mdu_rdy,
    input  logic [AW-1:0]          mdu_rd,
    input  logic [DW-1:0]          mdu_wd,
    input  logic [AW-1:0]          chk_a1,
    input  logic [AW-1:0]          chk_a2,
    output logic                   hit1,
    output logic                   hit2,
    output logic [AW-1:0]          rf_a3,
    output logic [DW-1:0]          rf_wd,
    output logic                   rf_we,
    output logic [$clog2(DEPTH):0] occ
);

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic [AW-1:0]            push_rd;
    logic [DW-1:0]            push_wd;
    logic                     pop;
    logic [AW-1:0]            head_rd;
    logic [DW-1:0]            head_wd;
    logic [DEPTH-1:0]         ent_vld;
    logic [DEPTH-1:0][AW-1:0] ent_rd;
    logic                     mem_acc;
    logic                     mdu_acc;
    wb_src_e                  src;

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .push_rd (push_rd),
        .push_wd (push_wd),
        .pop     (pop),
        .head_rd (head_rd),
        .head_wd (head_wd),
        .occ     (occ),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ent_vld (ent_vld),
        .ent_rd  (ent_rd)
    );

    // Full is taken from registered occupancy, so a same-cycle pop never frees a slot early
    assign mem_rdy = !fifo_full;
    assign mdu_rdy = !fifo_full && !mem_vld;
    assign mem_acc = mem_vld && mem_rdy;
    assign mdu_acc = mdu_vld && mdu_rdy;

    always_comb begin
        push    = 1'b0;
        push_rd = mdu_rd;
        push_wd = mdu_wd;
        if (mem_acc) begin
            push    = (mem_rd != '0);
            push_rd = mem_rd;
            push_wd = mem_wd;
        end else if (mdu_acc) begin
            push    = (mdu_rd != '0);
        end
    end

    // An ALU result owns the slot even when it targets r0
    always_comb begin
        src = SRC_NONE;
        if (alu_vld) begin
            src = SRC_ALU;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end
    end

    assign pop = (src == SRC_FIFO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= 1'b0;
            if (src == SRC_ALU && alu_rd != '0) begin
                rf_we <= 1'b1;
                rf_a3 <= alu_rd;
                rf_wd <= alu_wd;
            end else if (src == SRC_FIFO) begin
                rf_we <= 1'b1;
                rf_a3 <= head_rd;
                rf_wd <= head_wd;
            end
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && chk_a1 != '0 && ent_rd[i] == chk_a1) begin
                hit1 = 1'b1;
            end
            if (ent_vld[i] && chk_a2 != '0 && ent_rd[i] == chk_a2) begin
                hit2 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based model of the pending writes
// is compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] wd;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_vld = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_wd = '0;
    logic          mem_vld = 1'b0;
    logic          mem_rdy;
    logic [AW-1:0] mem_rd = '0;
    logic [DW-1:0] mem_wd = '0;
    logic          mdu_vld = 1'b0;
    logic          mdu_rdy;
    logic [AW-1:0] mdu_rd = '0;
    logic [DW-1:0] mdu_wd = '0;
    logic [AW-1:0] chk_a1 = '0;
    logic [AW-1:0] chk_a2 = '0;
    logic          hit1;
    logic          hit2;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd;
    logic          rf_we;
    logic [2:0]    occ;

    int checks   = 0;
    int failures = 0;

    ent_t          q[$];
    logic          exp_we    = 1'b0;
    logic [AW-1:0] exp_a3    = '0;
    logic [DW-1:0] exp_wd    = '0;
    logic          exp_known = 1'b0;
    logic          model_live = 1'b0;

    wb_arbiter #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .alu_vld (alu_vld),
        .alu_rd  (alu_rd),
        .alu_wd  (alu_wd),
        .mem_vld (mem_vld),
        .mem_rdy (mem_rdy),
        .mem_rd  (mem_rd),
        .mem_wd  (mem_wd),
        .mdu_vld (mdu_vld),
        .mdu_rdy (mdu_rdy),
        .mdu_rd  (mdu_rd),
        .mdu_wd  (mdu_wd),
        .chk_a1  (chk_a1),
        .chk_a2  (chk_a2),
        .hit1    (hit1),
        .hit2    (hit2),
        .rf_a3   (rf_a3),
        .rf_wd   (rf_wd),
        .rf_we   (rf_we),
        .occ     (occ)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance one clock; inputs set afterwards are sampled at the following edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        alu_vld = 1'b0;
        mem_vld = 1'b0;
        mdu_vld = 1'b0;
        chk_a1  = '0;
        chk_a2  = '0;
    endtask

    // Reference model: pending writes are a plain queue; one RF slot per cycle
    always @(posedge clk) begin
        logic is_full;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            exp_we     = 1'b0;
            exp_a3     = '0;
            exp_wd     = '0;
            exp_known  = 1'b1;
            model_live = 1'b1;
        end else if (model_live) begin
            is_full   = (q.size() == DEPTH);
            exp_known = 1'b0;
            if (alu_vld) begin
                exp_we = (alu_rd != 0);
                if (exp_we) begin
                    exp_a3 = alu_rd;
                    exp_wd = alu_wd;
                end
            end else if (q.size() > 0) begin
                e      = q.pop_front();
                exp_we = 1'b1;
                exp_a3 = e.rd;
                exp_wd = e.wd;
            end else begin
                exp_we = 1'b0;
            end
            if (!is_full) begin
                if (mem_vld) begin
                    if (mem_rd != 0) q.push_back('{mem_rd, mem_wd});
                end else if (mdu_vld) begin
                    if (mdu_rd != 0) q.push_back('{mdu_rd, mdu_wd});
                end
            end
        end
    end

    always @(negedge clk) begin
        logic h1;
        logic h2;
        if (model_live) begin
            h1 = 1'b0;
            h2 = 1'b0;
            foreach (q[i]) begin
                if (chk_a1 != 0 && q[i].rd == chk_a1) h1 = 1'b1;
                if (chk_a2 != 0 && q[i].rd == chk_a2) h2 = 1'b1;
            end
            checkOutput("model_occ", 32'(occ), 32'(q.size()));
            checkOutput("model_mem_rdy", 32'(mem_rdy), 32'(q.size() != DEPTH));
            checkOutput("model_mdu_rdy", 32'(mdu_rdy), 32'((q.size() != DEPTH) && !mem_vld));
            checkOutput("model_hit1", 32'(hit1), 32'(h1));
            checkOutput("model_hit2", 32'(hit2), 32'(h2));
            checkOutput("model_rf_we", 32'(rf_we), 32'(exp_we));
            if (exp_we || exp_known) begin
                checkOutput("model_rf_a3", 32'(rf_a3), 32'(exp_a3));
                checkOutput("model_rf_wd", rf_wd, exp_wd);
            end
        end
    end

    initial begin
        int pct;

        // Reset with every source asserting valid
        rst_n = 1'b0;
        alu_vld = 1'b1; alu_rd = 5'd9;  alu_wd = 32'h99;
        mem_vld = 1'b1; mem_rd = 5'd10; mem_wd = 32'hAA;
        mdu_vld = 1'b1; mdu_rd = 5'd11; mdu_wd = 32'hBB;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
        checkOutput("reset_occ", 32'(occ), 32'd0);
        checkOutput("reset_mem_rdy", 32'(mem_rdy), 32'd1);
        idleInputs();
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("reset_release_we", 32'(rf_we), 32'd0);

        // ALU bypass
        alu_vld = 1'b1; alu_rd = 5'd5; alu_wd = 32'h1234;
        applyStimulus();
        checkOutput("alu_we", 32'(rf_we), 32'd1);
        checkOutput("alu_a3", 32'(rf_a3), 32'd5);
        checkOutput("alu_wd", rf_wd, 32'h1234);
        alu_rd = 5'd0;
        applyStimulus();
        checkOutput("alu_r0_we", 32'(rf_we), 32'd0);
        idleInputs();

        // MEM beats MDU in the same cycle
        mem_vld = 1'b1; mem_rd = 5'd3; mem_wd = 32'hA;
        mdu_vld = 1'b1; mdu_rd = 5'd4; mdu_wd = 32'hB;
        #1;
        checkOutput("prio_mem_rdy", 32'(mem_rdy), 32'd1);
        checkOutput("prio_mdu_rdy", 32'(mdu_rdy), 32'd0);
        applyStimulus();
        mem_vld = 1'b0;
        #1;
        checkOutput("prio_mdu_rdy2", 32'(mdu_rdy), 32'd1);
        applyStimulus();
        checkOutput("prio_w1_a3", 32'(rf_a3), 32'd3);
        checkOutput("prio_w1_wd", rf_wd, 32'hA);
        mdu_vld = 1'b0;
        applyStimulus();
        checkOutput("prio_w2_we", 32'(rf_we), 32'd1);
        checkOutput("prio_w2_a3", 32'(rf_a3), 32'd4);
        checkOutput("prio_w2_wd", rf_wd, 32'hB);
        applyStimulus();
        checkOutput("prio_idle_we", 32'(rf_we), 32'd0);

        // Fill behind a busy ALU, then drain in order
        alu_vld = 1'b1; alu_rd = 5'd1; alu_wd = 32'h55;
        mem_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rd = 5'(10 + k);
            mem_wd = 32'h100 + 32'(k);
            applyStimulus();
        end
        mem_rd = 5'd14; mem_wd = 32'h104;
        #1;
        checkOutput("full_occ", 32'(occ), 32'd4);
        checkOutput("full_mem_rdy", 32'(mem_rdy), 32'd0);
        applyStimulus();
        checkOutput("full_hold_occ", 32'(occ), 32'd4);
        idleInputs();
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput("drain_a3", 32'(rf_a3), 32'(10 + k));
            checkOutput("drain_wd", rf_wd, 32'h100 + 32'(k));
            checkOutput("drain_occ", 32'(occ), 32'(3 - k));
        end
        checkOutput("drain_mem_rdy", 32'(mem_rdy), 32'd1);
        applyStimulus();
        checkOutput("drain_done_we", 32'(rf_we), 32'd0);

        // Hazard flags
        alu_vld = 1'b1; alu_rd = 5'd2; alu_wd = 32'h22;
        mem_vld = 1'b1; mem_rd = 5'd7; mem_wd = 32'h77;
        #1;
        chk_a1 = 5'd7;
        #1;
        checkOutput("hazard_same_cycle", 32'(hit1), 32'd0);
        applyStimulus();
        mem_vld = 1'b0; chk_a1 = 5'd7; chk_a2 = 5'd0;
        #1;
        checkOutput("hazard_hit1", 32'(hit1), 32'd1);
        checkOutput("hazard_hit2", 32'(hit2), 32'd0);
        alu_vld = 1'b0;
        applyStimulus();
        checkOutput("hazard_pop_a3", 32'(rf_a3), 32'd7);
        checkOutput("hazard_clear", 32'(hit1), 32'd0);
        idleInputs();

        // Reset discards queued entries
        alu_vld = 1'b1; alu_rd = 5'd6; alu_wd = 32'h66;
        mem_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_rd = 5'(20 + k);
            mem_wd = 32'h200 + 32'(k);
            applyStimulus();
        end
        mem_vld = 1'b0; chk_a1 = 5'd20; chk_a2 = 5'd22;
        #1;
        checkOutput("midrst_occ", 32'(occ), 32'd3);
        checkOutput("midrst_hit1_pre", 32'(hit1), 32'd1);
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        alu_vld = 1'b0;
        #1;
        checkOutput("midrst_occ0", 32'(occ), 32'd0);
        checkOutput("midrst_hit1", 32'(hit1), 32'd0);
        checkOutput("midrst_hit2", 32'(hit2), 32'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("midrst_no_write", 32'(rf_we), 32'd0);
        end
        idleInputs();

        // Randomized traffic with varying ALU pressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            case (c / 500)
                0:       pct = 80;
                1:       pct = 20;
                2:       pct = 50;
                3:       pct = 95;
                4:       pct = 10;
                default: pct = 60;
            endcase
            rst_n   = ($urandom_range(0, 199) != 0);
            alu_vld = ($urandom_range(0, 99) < pct);
            alu_rd  = 5'($urandom_range(0, 31));
            alu_wd  = $urandom;
            mem_vld = ($urandom_range(0, 1) == 1);
            mem_rd  = 5'($urandom_range(0, 7));
            mem_wd  = $urandom;
            mdu_vld = ($urandom_range(0, 2) != 0);
            mdu_rd  = 5'($urandom_range(0, 7));
            mdu_wd  = $urandom;
            chk_a1  = 5'($urandom_range(0, 7));
            chk_a2  = 5'($urandom_range(0, 7));
            applyStimulus();
        end

        rst_n = 1'b1;
        idleInputs();
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
        end
        checkOutput("final_occ", 32'(occ), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
